// File: rtl/text_console_writer.sv
// Text-mode console writer: turns an ASCII byte stream into char/attr writes
// for the text RAM. The optional TAB handling is enabled with TEXT_CONSOLE_TAB_EN.
module text_console_writer #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 30,
    parameter int unsigned COL_W      = 7,
    parameter int unsigned ROW_W      = 5,
    parameter int unsigned ADDR_W     = 12,
    parameter logic [7:0]  RESET_ATTR = 8'h0F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              attr_we,
    input  logic [7:0]        attr_in,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_char,
    output logic [7:0]        ram_attr,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR_ROW = 2'd1,
        CLEAR_ALL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [7:0]          attr_q, attr_d;
    logic                in_ready_q, in_ready_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [7:0]          ram_char_q, ram_char_d;
    logic [7:0]          ram_attr_q, ram_attr_d;
    logic [ADDR_W-1:0]   fill_q, fill_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic [ADDR_W-1:0]   cur_addr;
    logic                newline;

    assign cur_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

`ifdef TEXT_CONSOLE_TAB_EN
    logic [COL_W:0] tab_col;
    assign tab_col = (COL_W+1)'({col_q[COL_W-1:3], 3'b000}) + (COL_W+1)'(8);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            attr_q     <= RESET_ATTR;
            in_ready_q <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_char_q <= '0;
            ram_attr_q <= '0;
            fill_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            attr_q     <= attr_d;
            in_ready_q <= in_ready_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_char_q <= ram_char_d;
            ram_attr_q <= ram_attr_d;
            fill_q     <= fill_d;
            cnt_q      <= cnt_d;
        end
    end

    // Byte decode, cursor movement and clear sequencing
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        attr_d     = attr_we ? attr_in : attr_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_char_d = ram_char_q;
        ram_attr_d = ram_attr_q;
        fill_d     = fill_q;
        cnt_d      = cnt_q;
        newline    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        ram_we_d   = 1'b1;
                        ram_addr_d = cur_addr;
                        ram_char_d = in_data;
                        ram_attr_d = attr_d;
                        if (col_q == COL_W'(COLS - 1)) newline = 1'b1;
                        else                           col_d = col_q + COL_W'(1);
                    end else begin
                        case (in_data)
                            8'h0D: col_d = '0;
                            8'h0A: newline = 1'b1;
                            8'h08: if (col_q != '0) col_d = col_q - COL_W'(1);
                            8'h0C: begin
                                col_d   = '0;
                                row_d   = '0;
                                state_d = CLEAR_ALL;
                                fill_d  = '0;
                                cnt_d   = ADDR_W'(COLS * ROWS - 1);
                            end
`ifdef TEXT_CONSOLE_TAB_EN
                            8'h09: begin
                                if (tab_col >= (COL_W+1)'(COLS)) newline = 1'b1;
                                else                             col_d = COL_W'(tab_col);
                            end
`endif
                            default: ;
                        endcase
                    end

                    // Newline: wrapping off the last row clears the row we land on
                    if (newline) begin
                        col_d = '0;
                        if (row_q == ROW_W'(ROWS - 1)) begin
                            row_d   = '0;
                            state_d = CLEAR_ROW;
                            fill_d  = ADDR_W'(row_d) * ADDR_W'(COLS);
                            cnt_d   = ADDR_W'(COLS - 1);
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end
                end
            end
            CLEAR_ROW, CLEAR_ALL: begin
                ram_we_d   = 1'b1;
                ram_addr_d = fill_q;
                ram_char_d = 8'h20;
                ram_attr_d = attr_d;
                fill_d     = fill_q + ADDR_W'(1);
                cnt_d      = cnt_q - ADDR_W'(1);
                if (cnt_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    assign in_ready   = in_ready_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_char   = ram_char_q;
    assign ram_attr   = ram_attr_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed table-driven bench for text_console_writer plus clear/wrap/reset sequences.
module tb_text_console_writer;

    localparam int unsigned COLS = 80;
    localparam int unsigned ROWS = 30;
`ifdef TEXT_CONSOLE_TAB_EN
    localparam int unsigned TABCOL = 8;
`else
    localparam int unsigned TABCOL = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        attr_we;
    logic [7:0]  attr_in;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_char;
    logic [7:0]  ram_attr;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    text_console_writer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .attr_we    (attr_we),
        .attr_in    (attr_in),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_char   (ram_char),
        .ram_attr   (ram_attr),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        aw;
        logic [7:0]  ai;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  chr;
        logic [7:0]  attr;
        int          col;
        int          row;
        logic        ready;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    endtask

    // Drive one cycle of inputs, sample outputs 1 time unit after the edge
    task automatic step(input logic v, input logic [7:0] d, input logic aw, input logic [7:0] ai);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        attr_we  = aw;
        attr_in  = ai;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        attr_we  = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        int idx;
        int bad;
        int busy;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; attr_we = 1'b0; attr_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        //           valid data   aw ai     we addr  chr    attr   col      row ready
        vecs.push_back('{0, 8'h00, 0, 8'h00, 0, 12'd0, 8'h00, 8'h00, 0, 0, 1});
        vecs.push_back('{1, 8'h41, 0, 8'h00, 1, 12'd0, 8'h41, 8'h0F, 1, 0, 1});
        vecs.push_back('{1, 8'h42, 1, 8'h1E, 1, 12'd1, 8'h42, 8'h1E, 2, 0, 1});
        vecs.push_back('{1, 8'h43, 0, 8'h00, 1, 12'd2, 8'h43, 8'h1E, 3, 0, 1});
        vecs.push_back('{1, 8'h0D, 0, 8'h00, 0, 12'd0, 8'h00, 8'h00, 0, 0, 1});
        vecs.push_back('{1, 8'h08, 0, 8'h00, 0, 12'd0, 8'h00, 8'h00, 0, 0, 1});
        vecs.push_back('{1, 8'h78, 0, 8'h00, 1, 12'd0, 8'h78, 8'h1E, 1, 0, 1});
        vecs.push_back('{1, 8'h08, 0, 8'h00, 0, 12'd0, 8'h00, 8'h00, 0, 0, 1});
        vecs.push_back('{1, 8'h0A, 0, 8'h00, 0, 12'd0, 8'h00, 8'h00, 0, 1, 1});
        vecs.push_back('{1, 8'h7A, 0, 8'h00, 1, 12'd80, 8'h7A, 8'h1E, 1, 1, 1});
        vecs.push_back('{1, 8'h61, 0, 8'h00, 1, 12'd81, 8'h61, 8'h1E, 2, 1, 1});
        vecs.push_back('{1, 8'h62, 0, 8'h00, 1, 12'd82, 8'h62, 8'h1E, 3, 1, 1});
        vecs.push_back('{1, 8'h09, 0, 8'h00, 0, 12'd0, 8'h00, 8'h00, TABCOL, 1, 1});
        vecs.push_back('{0, 8'h5A, 1, 8'h2F, 0, 12'd0, 8'h00, 8'h00, TABCOL, 1, 1});
        vecs.push_back('{1, 8'h64, 0, 8'h00, 1, 12'(80 + TABCOL), 8'h64, 8'h2F, TABCOL + 1, 1, 1});
        vecs.push_back('{1, 8'h7F, 0, 8'h00, 0, 12'd0, 8'h00, 8'h00, TABCOL + 1, 1, 1});
        vecs.push_back('{1, 8'h01, 0, 8'h00, 0, 12'd0, 8'h00, 8'h00, TABCOL + 1, 1, 1});

        foreach (vecs[i]) begin
            if (i == 0) begin
                @(posedge clk); #1;
            end else begin
                step(vecs[i].valid, vecs[i].data, vecs[i].aw, vecs[i].ai);
            end
            check($sformatf("v%0d we", i), int'(ram_we), int'(vecs[i].we));
            if (vecs[i].we || i == 0) begin
                check($sformatf("v%0d addr", i), int'(ram_addr), int'(vecs[i].addr));
                check($sformatf("v%0d char", i), int'(ram_char), int'(vecs[i].chr));
                check($sformatf("v%0d attr", i), int'(ram_attr), int'(vecs[i].attr));
            end
            check($sformatf("v%0d col", i), int'(cursor_col), vecs[i].col);
            check($sformatf("v%0d row", i), int'(cursor_row), vecs[i].row);
            check($sformatf("v%0d ready", i), int'(in_ready), int'(vecs[i].ready));
        end

        // Walk down to the last row, then LF wraps and clears row 0
        step(1, 8'h0D, 0, 8'h00);
        for (int i = 0; i < 28; i++) step(1, 8'h0A, 0, 8'h00);
        check("row29", int'(cursor_row), 29);
        step(1, 8'h0A, 0, 8'h00);
        check("wrap col", int'(cursor_col), 0);
        check("wrap row", int'(cursor_row), 0);
        check("wrap ready0", int'(in_ready), 0);
        busy = 1; idx = 0; bad = 0;
        for (int c = 0; c < 200; c++) begin
            step(0, 8'h00, 0, 8'h00);
            if (ram_we) begin
                if (int'(ram_addr) != idx || ram_char != 8'h20 || ram_attr != 8'h2F) bad++;
                idx++;
            end
            if (in_ready) break;
            busy++;
        end
        check("wrap busy cycles", busy, 80);
        check("wrap writes", idx, 80);
        check("wrap write content", bad, 0);

        // Form feed: full screen clear
        step(1, 8'h0C, 0, 8'h00);
        check("ff ready0", int'(in_ready), 0);
        check("ff home", int'(cursor_col) + int'(cursor_row), 0);
        idx = 0; bad = 0;
        for (int c = 0; c < 3000; c++) begin
            step(0, 8'h00, 0, 8'h00);
            if (ram_we) begin
                if (int'(ram_addr) != idx || ram_char != 8'h20) bad++;
                idx++;
            end
            if (in_ready) break;
        end
        check("ff writes", idx, int'(COLS * ROWS));
        check("ff write content", bad, 0);
        check("ff ready1", int'(in_ready), 1);

        // Full line of printables: last lands at 79 and wraps to row 1
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            step(1, 8'(8'h30 + i % 10), 0, 8'h00);
            if (!ram_we || int'(ram_addr) != i || ram_char != 8'(8'h30 + i % 10)) bad++;
        end
        check("line write content", bad, 0);
        check("line addr79", int'(ram_addr), 79);
        check("line col", int'(cursor_col), 0);
        check("line row", int'(cursor_row), 1);
        step(0, 8'h00, 0, 8'h00);
        check("line no clear", int'(in_ready), 1);
        check("line we idle", int'(ram_we), 0);

        // Reset in the 10th cycle of CLEAR_ALL
        step(1, 8'h05, 0, 8'h00);
        step(1, 8'h0C, 0, 8'h00);
        for (int i = 0; i < 9; i++) step(0, 8'h00, 0, 8'h00);
        check("clr busy", int'(in_ready), 0);
        rst = 1'b1;
        step(0, 8'h00, 0, 8'h00);
        rst = 1'b0;
        check("rst we", int'(ram_we), 0);
        check("rst col", int'(cursor_col), 0);
        check("rst row", int'(cursor_row), 0);
        check("rst ready", int'(in_ready), 1);
        step(1, 8'h41, 0, 8'h00);
        check("rst attr", int'(ram_attr), 8'h0F);
        check("rst addr", int'(ram_addr), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
